// File: rtl/quiz_setup_fsm.sv
// Game-setup sequencer: collects player count, countdown and point values from the
// switch bank, validates each against parameterised bounds, and flags rejected entries.
module quiz_setup_fsm #(
    parameter int VAL_W       = 6,
    parameter int MIN_PEOPLE  = 2,
    parameter int MAX_PEOPLE  = 4,
    parameter int MAX_SECONDS = 60,
    parameter int MAX_POINTS  = 9,
    parameter int ERR_CYCLES  = 50_000_000,
    parameter int DEF_PEOPLE  = 2,
    parameter int DEF_SECONDS = 10,
    parameter int DEF_CORRECT = 1,
    parameter int DEF_MISTAKE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter_btn,
    input  logic             back_btn,
    input  logic             edit_btn,
    input  logic [VAL_W-1:0] input_val,
    output logic [VAL_W-1:0] output_light,
    output logic [2:0]       cur_set,
    output logic [VAL_W-1:0] num_people,
    output logic [VAL_W-1:0] count_seconds,
    output logic [VAL_W-1:0] correct_point,
    output logic [VAL_W-1:0] mistake_point,
    output logic             is_set_over,
    output logic             alarm_light
);

    typedef enum logic [2:0] {
        SET_PEOPLE  = 3'd0,
        SET_SECONDS = 3'd1,
        SET_CORRECT = 3'd2,
        SET_MISTAKE = 3'd3,
        DONE        = 3'd4
    } state_e;

    localparam int CNT_W = $clog2(ERR_CYCLES + 1);

    localparam logic [VAL_W-1:0] MIN_P  = VAL_W'(MIN_PEOPLE);
    localparam logic [VAL_W-1:0] MAX_P  = VAL_W'(MAX_PEOPLE);
    localparam logic [VAL_W-1:0] MAX_S  = VAL_W'(MAX_SECONDS);
    localparam logic [VAL_W-1:0] MAX_PT = VAL_W'(MAX_POINTS);
    localparam logic [VAL_W-1:0] ONE    = VAL_W'(1);

    // Button bits are ordered {edit, back, enter} throughout.
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make the three flops a real shift chain;
            // blocking ones would collapse it into a single stage.
            sync1_q <= {edit_btn, back_btn, enter_btn};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign evt = sync2_q & ~prev_q;

    state_e             state_q;
    logic [CNT_W-1:0]   alarm_cnt_q;
    logic [VAL_W-1:0]   people_q, seconds_q, correct_q, mistake_q, light_q;
    logic               over_q;
    logic               in_range;

    // Bounds for the field currently being edited.
    always_comb begin
        // NOTE: default first so every path assigns in_range and no latch is inferred.
        in_range = 1'b0;
        unique case (state_q)
            SET_PEOPLE:  in_range = (input_val >= MIN_P) && (input_val <= MAX_P);
            SET_SECONDS: in_range = (input_val >= ONE)   && (input_val <= MAX_S);
            SET_CORRECT,
            SET_MISTAKE: in_range = (input_val >= ONE)   && (input_val <= MAX_PT);
            default:     in_range = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SET_PEOPLE;
            people_q    <= VAL_W'(DEF_PEOPLE);
            seconds_q   <= VAL_W'(DEF_SECONDS);
            correct_q   <= VAL_W'(DEF_CORRECT);
            mistake_q   <= VAL_W'(DEF_MISTAKE);
            over_q      <= 1'b0;
            alarm_cnt_q <= '0;
            light_q     <= '0;
        end else begin
            light_q <= input_val;
            if (alarm_cnt_q != '0) alarm_cnt_q <= alarm_cnt_q - 1'b1;

            if (state_q == DONE) begin
                if (evt[2]) begin
                    state_q <= SET_PEOPLE;
                    over_q  <= 1'b0;
                end
            end else if (evt[0]) begin
                if (in_range) begin
                    alarm_cnt_q <= '0;
                    unique case (state_q)
                        SET_PEOPLE:  begin people_q  <= input_val; state_q <= SET_SECONDS; end
                        SET_SECONDS: begin seconds_q <= input_val; state_q <= SET_CORRECT; end
                        SET_CORRECT: begin correct_q <= input_val; state_q <= SET_MISTAKE; end
                        default:     begin
                            mistake_q <= input_val;
                            state_q   <= DONE;
                            over_q    <= 1'b1;
                        end
                    endcase
                end else begin
                    alarm_cnt_q <= CNT_W'(ERR_CYCLES);
                end
            end else if (evt[1] && state_q != SET_PEOPLE) begin
                state_q <= state_e'(state_q - 3'd1);
            end
        end
    end

    assign cur_set       = state_q;
    assign num_people    = people_q;
    assign count_seconds = seconds_q;
    assign correct_point = correct_q;
    assign mistake_point = mistake_q;
    assign is_set_over   = over_q;
    assign alarm_light   = (alarm_cnt_q != '0);
    assign output_light  = light_q;

endmodule

// File: tb/tb_quiz_setup_fsm.sv
// Directed bench for quiz_setup_fsm: a table of button presses with expected settings,
// followed by hand-written sequences for latency, alarm duration, held buttons and reset.
module tb_quiz_setup_fsm;

    localparam int VAL_W = 6;
    localparam int ERR   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enter_btn = 1'b0, back_btn = 1'b0, edit_btn = 1'b0;
    logic [VAL_W-1:0] input_val = '0;
    logic [VAL_W-1:0] output_light, num_people, count_seconds, correct_point, mistake_point;
    logic [2:0]       cur_set;
    logic             is_set_over, alarm_light;

    int n_cmp  = 0;
    int n_fail = 0;

    quiz_setup_fsm #(.VAL_W(VAL_W), .ERR_CYCLES(ERR)) dut (
        .clk(clk), .rst(rst),
        .enter_btn(enter_btn), .back_btn(back_btn), .edit_btn(edit_btn),
        .input_val(input_val), .output_light(output_light), .cur_set(cur_set),
        .num_people(num_people), .count_seconds(count_seconds),
        .correct_point(correct_point), .mistake_point(mistake_point),
        .is_set_over(is_set_over), .alarm_light(alarm_light)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] B_EN = 3'b001, B_BK = 3'b010, B_ED = 3'b100;

    typedef struct {
        logic [2:0] btns;   // {edit, back, enter}
        logic [5:0] val;
        logic [2:0] cs;
        logic [5:0] p, s, c, m;
        logic       over, alarm;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cs, input int p, input int s,
                             input int c, input int m, input int over, input int alarm);
        check({tag, " cur_set"},       cur_set,       cs);
        check({tag, " num_people"},    num_people,    p);
        check({tag, " count_seconds"}, count_seconds, s);
        check({tag, " correct_point"}, correct_point, c);
        check({tag, " mistake_point"}, mistake_point, m);
        check({tag, " is_set_over"},   is_set_over,   over);
        check({tag, " alarm_light"},   alarm_light,   alarm);
    endtask

    task automatic drive(input logic [2:0] b);
        {edit_btn, back_btn, enter_btn} = b;
    endtask

    // Raise buttons at a negedge, hold 4 cycles, release, settle 2 cycles.
    task automatic press(input logic [2:0] b, input logic [5:0] v);
        input_val = v;
        drive(b);
        repeat (4) @(negedge clk);
        drive(3'b000);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{B_EN, 6'd3,  3'd1, 6'd3, 6'd10, 6'd1, 6'd1, 1'b0, 1'b0};
        vecs[1]  = '{B_EN, 6'd30, 3'd2, 6'd3, 6'd30, 6'd1, 6'd1, 1'b0, 1'b0};
        vecs[2]  = '{B_EN, 6'd5,  3'd3, 6'd3, 6'd30, 6'd5, 6'd1, 1'b0, 1'b0};
        vecs[3]  = '{B_EN, 6'd2,  3'd4, 6'd3, 6'd30, 6'd5, 6'd2, 1'b1, 1'b0};
        vecs[4]  = '{B_EN, 6'd7,  3'd4, 6'd3, 6'd30, 6'd5, 6'd2, 1'b1, 1'b0};
        vecs[5]  = '{B_BK, 6'd7,  3'd4, 6'd3, 6'd30, 6'd5, 6'd2, 1'b1, 1'b0};
        vecs[6]  = '{B_ED, 6'd7,  3'd0, 6'd3, 6'd30, 6'd5, 6'd2, 1'b0, 1'b0};
        vecs[7]  = '{B_BK, 6'd7,  3'd0, 6'd3, 6'd30, 6'd5, 6'd2, 1'b0, 1'b0};
        vecs[8]  = '{B_EN, 6'd5,  3'd0, 6'd3, 6'd30, 6'd5, 6'd2, 1'b0, 1'b1};
        vecs[9]  = '{B_EN, 6'd1,  3'd0, 6'd3, 6'd30, 6'd5, 6'd2, 1'b0, 1'b1};
        vecs[10] = '{B_EN, 6'd4,  3'd1, 6'd4, 6'd30, 6'd5, 6'd2, 1'b0, 1'b0};
        vecs[11] = '{B_EN, 6'd0,  3'd1, 6'd4, 6'd30, 6'd5, 6'd2, 1'b0, 1'b1};
        vecs[12] = '{B_EN, 6'd60, 3'd2, 6'd4, 6'd60, 6'd5, 6'd2, 1'b0, 1'b0};
        vecs[13] = '{B_EN, 6'd10, 3'd2, 6'd4, 6'd60, 6'd5, 6'd2, 1'b0, 1'b1};
        vecs[14] = '{B_EN, 6'd9,  3'd3, 6'd4, 6'd60, 6'd9, 6'd2, 1'b0, 1'b0};
        vecs[15] = '{B_BK, 6'd0,  3'd2, 6'd4, 6'd60, 6'd9, 6'd2, 1'b0, 1'b0};
        vecs[16] = '{B_BK, 6'd0,  3'd1, 6'd4, 6'd60, 6'd9, 6'd2, 1'b0, 1'b0};
        vecs[17] = '{B_BK, 6'd0,  3'd0, 6'd4, 6'd60, 6'd9, 6'd2, 1'b0, 1'b0};
        vecs[18] = '{B_BK, 6'd0,  3'd0, 6'd4, 6'd60, 6'd9, 6'd2, 1'b0, 1'b0};

        // Reset values, checked while reset is held and after release.
        #12;
        check_all("in_reset", 0, 2, 10, 1, 1, 0, 0);
        check("in_reset output_light", output_light, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all("after_reset", 0, 2, 10, 1, 1, 0, 0);

        for (int i = 0; i < 19; i++) begin
            press(vecs[i].btns, vecs[i].val);
            check_all($sformatf("vec%0d", i), vecs[i].cs, vecs[i].p, vecs[i].s,
                      vecs[i].c, vecs[i].m, vecs[i].over, vecs[i].alarm);
        end

        // Event from a raw rise sampled at edge k must act at edge k+2, not earlier.
        input_val = 6'd3;
        drive(B_EN);
        repeat (2) @(negedge clk);
        check("latency cur_set before k+2", cur_set, 0);
        @(negedge clk);
        check("latency cur_set at k+2", cur_set, 1);
        check("latency num_people", num_people, 3);
        drive(3'b000);
        repeat (2) @(negedge clk);

        // Reject in SET_SECONDS: alarm high for exactly ERR cycles.
        input_val = 6'd0;
        drive(B_EN);
        repeat (3) @(negedge clk);
        check("alarm rises", alarm_light, 1);
        repeat (7) @(negedge clk);
        check("alarm last cycle", alarm_light, 1);
        @(negedge clk);
        check("alarm falls", alarm_light, 0);
        check("alarm cur_set held", cur_set, 1);
        drive(3'b000);
        repeat (2) @(negedge clk);

        // Held enter with 61: exactly one reject, alarm expires while still held.
        input_val = 6'd61;
        drive(B_EN);
        repeat (21) @(negedge clk);
        check("held 61 alarm single", alarm_light, 0);
        check("held 61 cur_set", cur_set, 1);
        check("held 61 count_seconds", count_seconds, 60);
        drive(3'b000);
        repeat (2) @(negedge clk);

        // Held enter with 60: exactly one advance (SET_CORRECT then rejects nothing).
        input_val = 6'd60;
        drive(B_EN);
        repeat (21) @(negedge clk);
        check("held 60 cur_set", cur_set, 2);
        check("held 60 count_seconds", count_seconds, 60);
        check("held 60 alarm", alarm_light, 0);
        drive(3'b000);
        repeat (2) @(negedge clk);

        // enter beats back when both fire together.
        press(B_EN | B_BK, 6'd4);
        check("enter+back cur_set", cur_set, 3);
        check("enter+back correct_point", correct_point, 4);

        // is_set_over rises in the same cycle DONE is entered.
        input_val = 6'd1;
        drive(B_EN);
        repeat (2) @(negedge clk);
        check("over before k+2", is_set_over, 0);
        @(negedge clk);
        check("over at k+2", is_set_over, 1);
        check("done cur_set", cur_set, 4);
        drive(3'b000);
        repeat (2) @(negedge clk);

        // enter and edit together in DONE resolve as edit.
        press(B_EN | B_ED, 6'd5);
        check_all("enter+edit", 0, 3, 60, 4, 1, 0, 0);

        press(B_EN, 6'd4);
        check("pre-reset cur_set", cur_set, 1);

        // output_light echoes input_val one cycle later.
        input_val = 6'd37;
        @(posedge clk);
        #1;
        check("output_light echo", output_light, 37);

        // Asynchronous reset mid-setup takes effect without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all("mid_reset", 0, 2, 10, 1, 1, 0, 0);
        check("mid_reset output_light", output_light, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quiz_setup_fsm.md
Name: quiz_setup_fsm

Overview:
- Parametrised successor to the answering machine's game-setup sequencer.
- Collects four game settings from the switch bank: player count, countdown seconds, correct-answer points and mistake points.
- Validates each setting against parameterised bounds and supports stepping back one field. Settings can be re-edited after setup completes.
- Feeds the round controller and the scoreboard. Runs on the system clock, with internal synchronisation of the raw push-buttons.

Parameters:
- VAL_W, 6, width of input_val and of every setting register.
- MIN_PEOPLE, 2, minimum legal player count.
- MAX_PEOPLE, 4, maximum legal player count (channel count of the machine).
- MAX_SECONDS, 60, maximum countdown; minimum is 1.
- MAX_POINTS, 9, maximum for correct and mistake points; minimum is 1.
- ERR_CYCLES, 50_000_000, number of cycles alarm_light stays high after a rejected entry.
- DEF_PEOPLE / DEF_SECONDS / DEF_CORRECT / DEF_MISTAKE, 2 / 10 / 1 / 1, reset values of the settings. Each must lie within its bounds.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, active-low, asynchronous.
- enter_btn  in  1  raw confirm button.
- back_btn  in  1  raw previous-field button.
- edit_btn  in  1  raw re-edit request.
- input_val  in  VAL_W  switch value.
- output_light  out  VAL_W  registered echo of input_val.
- cur_set  out  3  current state encoding.
- num_people  out  VAL_W  accepted player count.
- count_seconds  out  VAL_W  accepted countdown.
- correct_point  out  VAL_W  accepted correct points.
- mistake_point  out  VAL_W  accepted mistake points.
- is_set_over  out  1  high while in DONE.
- alarm_light  out  1  rejected-entry indicator.

Behaviour:
- Reset (rst low, asynchronous):
  - state = SET_PEOPLE, cur_set = 0.
  - Settings take their DEF_* values.
  - is_set_over = 0, alarm_light = 0, alarm counter = 0, output_light = 0.
  - All synchroniser flops = 0.
- Button handling:
  - Each button passes through a 2-flop synchroniser plus a previous-value flop.
  - The event is sync2 & ~prev, i.e. one cycle per rising edge.
  - Button held high produces exactly one event.
  - An event generated from a raw rise first sampled at edge k acts at edge k+2.
- output_light = input_val delayed by one cycle.
- States (cur_set encoding): SET_PEOPLE 0, SET_SECONDS 1, SET_CORRECT 2, SET_MISTAKE 3, DONE 4.
- enter event in a SET state:
  - If input_val is within that field's [min, max], the field register loads input_val, the state advances by one, and the alarm counter clears.
  - Otherwise the field keeps its previous value, the state holds, and the alarm counter loads ERR_CYCLES.
  - From SET_MISTAKE, a valid entry moves to DONE, and is_set_over rises in the same cycle.
- back event:
  - In SET_SECONDS, SET_CORRECT or SET_MISTAKE, moves to the previous state. No register changes.
  - Ignored in SET_PEOPLE and DONE.
- edit event:
  - In DONE, moves to SET_PEOPLE, is_set_over = 0, settings retained.
  - Ignored elsewhere.
- Simultaneous events: enter has priority over back. enter and edit together in DONE resolve as edit.
- enter in DONE is ignored.
- alarm_light = (alarm counter != 0). The counter decrements each cycle while nonzero. A new reject reloads it to ERR_CYCLES.
- Comparisons are unsigned at VAL_W width. Values at or above 2^VAL_W cannot occur.
- Reset asserted mid-setup returns everything to the reset values within the same cycle. Partially entered settings are discarded.

Test Plan:
- Reset with rst=0, then release -> cur_set=0, num_people=2, count_seconds=10, correct_point=1, mistake_point=1, is_set_over=0, alarm_light=0.
- Enter 3, 30, 5, 2 in sequence -> settings 3/30/5/2, cur_set reaches 4, is_set_over=1 two cycles after the final synchronised edge.
- In SET_PEOPLE enter 5, then 1 (ERR_CYCLES=8) -> num_people stays 2, cur_set stays 0, alarm_light high exactly 8 cycles after the last reject. Then enter 4 -> accepted, alarm_light low.
- In SET_CORRECT press back twice, then back again -> cur_set 2→1→0→0, all values unchanged.
- In DONE press edit -> cur_set=0, is_set_over=0, settings retained. Enter with edit asserted together in DONE resolves as edit.
- Hold enter_btn high for 20 cycles in SET_SECONDS with input 61 -> exactly one reject. With input 60 -> exactly one advance. Assert rst mid-sequence -> immediate reset values.
